// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences one byte/half/word RAM access per request.
// It handles alignment errors, the ram_mfc timeout and load sign/zero extension.
module mem_access_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        rw,
  input  logic [1:0]  size,
  input  logic        sign,
  input  logic [8:0]  addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        ram_enable,
  output logic        ram_rw,
  output logic [1:0]  ram_length,
  output logic [8:0]  ram_address,
  output logic [31:0] ram_data_in,
  input  logic        ram_mfc,
  input  logic [31:0] ram_data_out
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE, ERR} state_t;
  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        sign_q, sign_d;
  logic        busy_q, busy_d, done_q, done_d, err_q, err_d, en_q, en_d;
  logic [31:0] rdata_q, rdata_d;
  logic        ram_rw_q, ram_rw_d;
  logic [1:0]  ram_length_q, ram_length_d;
  logic [8:0]  ram_address_q, ram_address_d;
  logic [31:0] ram_data_in_q, ram_data_in_d;
  logic        bad;
  logic [31:0] ext, masked;
  assign bad = (size == 2'b11) || (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00);
  assign masked = size == 2'b00 ? {24'b0, wdata[7:0]} : size == 2'b01 ? {16'b0, wdata[15:0]} : wdata;
  assign ext = ram_length_q == 2'b00 ? {{24{sign_q & ram_data_out[7]}}, ram_data_out[7:0]} :
               ram_length_q == 2'b01 ? {{16{sign_q & ram_data_out[15]}}, ram_data_out[15:0]} : ram_data_out;
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    sign_d        = sign_q;
    rdata_d       = rdata_q;
    ram_rw_d      = ram_rw_q;
    ram_length_d  = ram_length_q;
    ram_address_d = ram_address_q;
    ram_data_in_d = ram_data_in_q;
    case (state_q)
      IDLE: if (req) begin
        sign_d = sign;
        // Misaligned requests never reach the RAM, so its drive lines keep their old values.
        if (bad) state_d = ERR;
        else begin
          state_d       = ACCESS;
          cnt_d         = '0;
          ram_rw_d      = rw;
          ram_length_d  = size;
          ram_address_d = addr;
          ram_data_in_d = masked;
        end
      end
      ACCESS: begin
        cnt_d = cnt_q + CW'(1);
        if (ram_mfc) begin
          state_d = DONE;
          rdata_d = ram_rw_q ? ext : rdata_q;
        end else if (cnt_q == CW'(TIMEOUT - 1)) state_d = ERR;
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
    done_d = state_d == DONE || state_d == ERR;
    err_d  = state_d == ERR;
    en_d   = state_d == ACCESS;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      sign_q        <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      en_q          <= 1'b0;
      rdata_q       <= '0;
      ram_rw_q      <= 1'b0;
      ram_length_q  <= '0;
      ram_address_q <= '0;
      ram_data_in_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      sign_q        <= sign_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_q         <= err_d;
      en_q          <= en_d;
      rdata_q       <= rdata_d;
      ram_rw_q      <= ram_rw_d;
      ram_length_q  <= ram_length_d;
      ram_address_q <= ram_address_d;
      ram_data_in_q <= ram_data_in_d;
    end
  end
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign rdata       = rdata_q;
  assign ram_enable  = en_q;
  assign ram_rw      = ram_rw_q;
  assign ram_length  = ram_length_q;
  assign ram_address = ram_address_q;
  assign ram_data_in = ram_data_in_q;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: scenario tasks with a scoreboard of expected completions.
module tb_mem_access_ctrl;
  logic clk = 0, rst_n = 0, req = 0, rw = 0, sign = 0, ram_mfc = 0;
  logic [1:0] size = 0;
  logic [8:0] addr = 0;
  logic [31:0] wdata = 0, ram_data_out = 0;
  logic busy, done, err, ram_enable, ram_rw;
  logic [31:0] rdata, ram_data_in;
  logic [1:0] ram_length;
  logic [8:0] ram_address;
  mem_access_ctrl #(.TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .rw(rw), .size(size), .sign(sign),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .err(err), .rdata(rdata),
    .ram_enable(ram_enable), .ram_rw(ram_rw), .ram_length(ram_length),
    .ram_address(ram_address), .ram_data_in(ram_data_in), .ram_mfc(ram_mfc),
    .ram_data_out(ram_data_out));
  always #5 clk = ~clk;
  typedef struct {logic e; logic [31:0] rd; int en; int lat;} exp_t;
  exp_t sb[$];
  exp_t x;
  int errors = 0, checks = 0;
  int en_cyc, lat;
  logic o_err, o_rw;
  logic [1:0] o_len;
  logic [8:0] o_addr;
  logic [31:0] o_din, o_rd;
  task automatic run(input logic r, input logic [1:0] s, input logic sg, input logic [8:0] a,
                     input logic [31:0] wd, input logic [31:0] dout, input int mfc_at);
    bit got = 0;
    @(negedge clk);
    req = 1; rw = r; size = s; sign = sg; addr = a; wdata = wd; ram_data_out = dout; ram_mfc = 0;
    @(posedge clk); #1 req = 0;
    en_cyc = 0; lat = -1;
    for (int n = 0; n < 100 && !got; n++) begin
      @(negedge clk);
      if (ram_enable) begin
        if (en_cyc == 0) begin o_rw = ram_rw; o_len = ram_length; o_addr = ram_address; o_din = ram_data_in; end
        en_cyc++;
      end
      if (done) begin got = 1; o_err = err; o_rd = rdata; lat = n; end
      ram_mfc = ram_enable && (en_cyc - 1 == mfc_at);
    end
    ram_mfc = 0;
    checks++;
    if (!got) begin errors++; $display("FAIL done_timeout: no done within 100 cycles"); end
  endtask
  task automatic test_reset;
    #3 rst_n = 0; #1;
    checks++;
    if ({busy, done, err, ram_enable, ram_rw, ram_length, ram_address, ram_data_in, rdata} !== '0) begin
      errors++; $display("FAIL reset_outputs: got busy=%b done=%b en=%b rdata=%h din=%h, want all 0", busy, done, ram_enable, rdata, ram_data_in);
    end
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask
  task automatic test_read_byte;
    x = '{1'b0, 32'hFFFFFF85, 3, 3}; sb.push_back(x);
    run(1, 2'b00, 1, 9'd0, 32'h0, 32'h00000085, 2);
    x = sb.pop_front();
    checks++; if (en_cyc !== x.en) begin errors++; $display("FAIL rb_en_cycles: got %0d want %0d", en_cyc, x.en); end
    checks++; if (o_len !== 2'b00 || o_rw !== 1'b1) begin errors++; $display("FAIL rb_ram_ctl: got len=%b rw=%b want 00 1", o_len, o_rw); end
    checks++; if (o_rd !== x.rd || o_err !== x.e) begin errors++; $display("FAIL rb_signed: got %h err=%b want %h err=%b", o_rd, o_err, x.rd, x.e); end
    checks++; if (lat !== x.lat) begin errors++; $display("FAIL rb_latency: got %0d want %0d", lat, x.lat); end
    @(negedge clk);
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rb_pulse: got done=%b busy=%b want 0 0", done, busy); end
    x = '{1'b0, 32'h00000085, 3, 3}; sb.push_back(x);
    run(1, 2'b00, 0, 9'd0, 32'h0, 32'h00000085, 2);
    x = sb.pop_front();
    checks++; if (o_rd !== x.rd || o_err !== x.e) begin errors++; $display("FAIL rb_unsigned: got %h err=%b want %h err=%b", o_rd, o_err, x.rd, x.e); end
  endtask
  task automatic test_write_half;
    x = '{1'b0, 32'h00000085, 1, 1}; sb.push_back(x);
    run(0, 2'b01, 1, 9'd2, 32'hABCD0400, 32'hFFFFFFFF, 0);
    x = sb.pop_front();
    checks++; if (o_din !== 32'h00000400) begin errors++; $display("FAIL wh_data_in: got %h want 00000400", o_din); end
    checks++; if (o_rw !== 1'b0 || o_len !== 2'b01 || o_addr !== 9'd2) begin errors++; $display("FAIL wh_ram_ctl: got rw=%b len=%b addr=%0d want 0 01 2", o_rw, o_len, o_addr); end
    checks++; if (o_err !== x.e || o_rd !== x.rd) begin errors++; $display("FAIL wh_result: got err=%b rdata=%h want %b %h", o_err, o_rd, x.e, x.rd); end
    @(negedge clk);
    checks++; if (ram_address !== 9'd2 || ram_data_in !== 32'h400 || ram_enable !== 1'b0) begin errors++; $display("FAIL wh_hold: got addr=%0d din=%h en=%b want 2 00000400 0", ram_address, ram_data_in, ram_enable); end
  endtask
  task automatic test_misaligned;
    x = '{1'b1, 32'h00000085, 0, 0}; sb.push_back(x);
    run(1, 2'b10, 0, 9'd9, 32'h0, 32'h12345678, 0);
    x = sb.pop_front();
    checks++; if (en_cyc !== x.en || lat !== x.lat) begin errors++; $display("FAIL mis_word: got en=%0d lat=%0d want %0d %0d", en_cyc, lat, x.en, x.lat); end
    checks++; if (o_err !== x.e || o_rd !== x.rd) begin errors++; $display("FAIL mis_word_err: got err=%b rdata=%h want %b %h", o_err, o_rd, x.e, x.rd); end
    checks++; if (ram_address !== 9'd2) begin errors++; $display("FAIL mis_hold: got addr=%0d want 2", ram_address); end
    x = '{1'b1, 32'h00000085, 0, 0}; sb.push_back(x);
    run(1, 2'b01, 0, 9'd5, 32'h0, 32'h0, 0);
    x = sb.pop_front();
    checks++; if (en_cyc !== x.en || o_err !== x.e) begin errors++; $display("FAIL mis_half: got en=%0d err=%b want %0d %b", en_cyc, o_err, x.en, x.e); end
    x = '{1'b1, 32'h00000085, 0, 0}; sb.push_back(x);
    run(1, 2'b11, 0, 9'd0, 32'h0, 32'h0, 0);
    x = sb.pop_front();
    checks++; if (en_cyc !== x.en || o_err !== x.e) begin errors++; $display("FAIL size_11: got en=%0d err=%b want %0d %b", en_cyc, o_err, x.en, x.e); end
  endtask
  task automatic test_read_half_word;
    x = '{1'b0, 32'hFFFF8001, 2, 2}; sb.push_back(x);
    run(1, 2'b01, 1, 9'd6, 32'h0, 32'h55558001, 1);
    x = sb.pop_front();
    checks++; if (o_rd !== x.rd || o_addr !== 9'd6) begin errors++; $display("FAIL rh_signed: got %h addr=%0d want %h 6", o_rd, o_addr, x.rd); end
    x = '{1'b0, 32'h80C0FFEE, 5, 5}; sb.push_back(x);
    run(1, 2'b10, 1, 9'd12, 32'h0, 32'h80C0FFEE, 4);
    x = sb.pop_front();
    checks++; if (o_rd !== x.rd || en_cyc !== x.en || o_len !== 2'b10) begin errors++; $display("FAIL rw_word: got %h en=%0d len=%b want %h %0d 10", o_rd, en_cyc, o_len, x.rd, x.en); end
  endtask
  task automatic test_timeout;
    x = '{1'b1, 32'h80C0FFEE, 16, 16}; sb.push_back(x);
    run(1, 2'b10, 0, 9'd8, 32'h0, 32'h11111111, -1);
    x = sb.pop_front();
    checks++; if (en_cyc !== x.en || lat !== x.lat) begin errors++; $display("FAIL to_cycles: got en=%0d lat=%0d want %0d %0d", en_cyc, lat, x.en, x.lat); end
    checks++; if (o_err !== x.e || o_rd !== x.rd) begin errors++; $display("FAIL to_err: got err=%b rdata=%h want %b %h", o_err, o_rd, x.e, x.rd); end
    @(negedge clk);
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL to_idle: got busy=%b done=%b want 0 0", busy, done); end
    x = '{1'b0, 32'h00001234, 16, 16}; sb.push_back(x);
    run(1, 2'b10, 0, 9'd8, 32'h0, 32'h00001234, 15);
    x = sb.pop_front();
    checks++; if (o_err !== x.e || en_cyc !== x.en || o_rd !== x.rd) begin errors++; $display("FAIL to_last_mfc: got err=%b en=%0d rdata=%h want %b %0d %h", o_err, en_cyc, o_rd, x.e, x.en, x.rd); end
  endtask
  task automatic test_reset_in_access;
    int seen = 0;
    @(negedge clk);
    req = 1; rw = 1; size = 2'b10; sign = 0; addr = 9'd4; ram_mfc = 0;
    @(posedge clk); #1 req = 0;
    @(posedge clk); @(posedge clk); #3 rst_n = 0; #1;
    checks++; if (ram_enable !== 1'b0 || busy !== 1'b0 || rdata !== 32'h0) begin errors++; $display("FAIL rst_access: got en=%b busy=%b rdata=%h want 0 0 0", ram_enable, busy, rdata); end
    repeat (3) begin @(negedge clk); seen += done; end
    rst_n = 1;
    repeat (3) begin @(negedge clk); seen += done; end
    checks++; if (seen !== 0) begin errors++; $display("FAIL rst_no_done: got %0d done cycles want 0", seen); end
    x = '{1'b0, 32'h0000007F, 1, 1}; sb.push_back(x);
    run(1, 2'b00, 1, 9'd3, 32'h0, 32'h0000007F, 0);
    x = sb.pop_front();
    checks++; if (lat !== x.lat || o_rd !== x.rd) begin errors++; $display("FAIL rst_first_req: got lat=%0d rdata=%h want %0d %h", lat, o_rd, x.lat, x.rd); end
  endtask
  task automatic test_back_to_back;
    int dones = 0, bad_gap = 0;
    logic prev_done = 0;
    @(negedge clk);
    req = 1; rw = 1; size = 2'b00; sign = 0; addr = 9'd1; ram_data_out = 32'hAA; ram_mfc = 1;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      if (prev_done && busy !== 1'b0) bad_gap++;
      if (prev_done && ram_enable !== 1'b0) bad_gap++;
      dones += done;
      prev_done = done;
    end
    req = 0; ram_mfc = 0;
    checks++; if (dones !== 3) begin errors++; $display("FAIL b2b_count: got %0d dones want 3", dones); end
    checks++; if (bad_gap !== 0) begin errors++; $display("FAIL b2b_gap: got %0d non-idle cycles after done want 0", bad_gap); end
    checks++; if (rdata !== 32'h000000AA) begin errors++; $display("FAIL b2b_rdata: got %h want 000000aa", rdata); end
    repeat (3) @(negedge clk);
  endtask
  initial begin
    test_reset;
    test_read_byte;
    test_write_half;
    test_misaligned;
    test_read_half_word;
    test_timeout;
    test_reset_in_access;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 The module SHALL have one parameter: TIMEOUT, default 16, the maximum number of ACCESS cycles to wait for ram_mfc.
REQ-002 clk  input  1  the single clock; all state changes occur on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req  input  1  access request from the control unit, level-sensitive, sampled only in IDLE.
REQ-005 rw  input  1  1 = read (load), 0 = write (store).
REQ-006 size  input  2  00 = byte, 01 = halfword, 10 = word, 11 = illegal.
REQ-007 sign  input  1  1 = sign-extend loads, 0 = zero-extend loads.
REQ-008 addr  input  9  byte address.
REQ-009 wdata  input  32  store data, right-justified.
REQ-010 busy  output  1  high whenever state is not IDLE.
REQ-011 done  output  1  one-cycle completion pulse.
REQ-012 err  output  1  one-cycle error pulse, coincident with done.
REQ-013 rdata  output  32  extended load result, held until the next completed read.
REQ-014 ram_enable  output  1  drives the RAM enable.
REQ-015 ram_rw  output  1  drives the RAM read_write.
REQ-016 ram_length  output  2  drives the RAM data_length.
REQ-017 ram_address  output  9  drives the RAM address.
REQ-018 ram_data_in  output  32  drives the RAM data_in.
REQ-019 ram_mfc  input  1  memory-function-complete from the RAM.
REQ-020 ram_data_out  input  32  read data from the RAM.

Function
REQ-021 The FSM SHALL have exactly the states IDLE, ACCESS, DONE and ERR.
REQ-022 In IDLE with req=1, the module SHALL capture rw, size, sign, addr and wdata into internal registers on that edge.
REQ-023 If the captured request is misaligned (size=01 with addr[0]=1, size=10 with addr[1:0]!=0) or has size=11, the next state SHALL be ERR; otherwise the next state SHALL be ACCESS.
REQ-024 While in ACCESS, ram_enable SHALL be 1.
REQ-025 While in ACCESS, ram_rw, ram_length and ram_address SHALL equal the captured values.
REQ-026 While in ACCESS, ram_data_in SHALL equal the captured wdata masked to the access size (byte: bits 7:0; half: bits 15:0; upper bits 0).
REQ-027 In ACCESS, when ram_mfc=1 is sampled, the next state SHALL be DONE.
REQ-028 On that same edge, for a read, rdata SHALL load ram_data_out extended from bit 7 (byte), bit 15 (half) or unchanged (word), according to the captured sign.
REQ-029 In ACCESS, a cycle counter SHALL start at 0 on entry and increment each cycle.
REQ-030 If the counter reaches TIMEOUT-1 with ram_mfc=0, the next state SHALL be ERR.
REQ-031 If ram_mfc=1 in that same cycle, the transition SHALL be to DONE and SHALL NOT be an error.
REQ-032 DONE SHALL assert done=1 and err=0 for exactly one cycle with ram_enable=0, then go to IDLE.
REQ-033 ERR SHALL assert done=1 and err=1 for exactly one cycle with ram_enable=0, then go to IDLE.
REQ-034 rdata SHALL be unchanged by writes and by error terminations.
REQ-035 req outside IDLE SHALL be ignored.
REQ-036 If req is held high, the next access SHALL be captured on the edge where the state is IDLE, giving a minimum of one idle cycle between accesses.
REQ-037 When not in ACCESS, ram_enable SHALL be 0.
REQ-038 When not in ACCESS, ram_rw, ram_length, ram_address and ram_data_in SHALL hold their last values.
REQ-039 Latency SHALL be: req sampled at edge E; ram_enable high from E; ram_mfc sampled high at edge M; done high for the cycle after M.
REQ-040 Misaligned-request latency SHALL be: done/err high for the cycle after E.

Reset
REQ-041 When rst_n=0, the module SHALL, without waiting for clk, set state to IDLE and all outputs to 0 (busy, done, err, rdata, ram_enable, ram_rw, ram_length, ram_address, ram_data_in) and clear the counter.
REQ-042 Reset asserted during ACCESS SHALL drop ram_enable immediately and SHALL abandon the access without asserting done.
REQ-043 After rst_n rises, the first req SHALL be accepted on the next rising edge.

Verification
REQ-044 Read byte 0x85 at address 0 with sign=1, mfc two cycles later: ram_enable high for 3 cycles, ram_length=00, then rdata=0xFFFFFF85 and done pulses 1 cycle.
REQ-045 Same read with sign=0: rdata=0x00000085.
REQ-046 Write half, wdata=0xABCD0400, addr=2: ram_data_in=0x00000400, ram_rw=0, ram_length=01, done with err=0, rdata unchanged.
REQ-047 Word read at addr=9: no ram_enable pulse; done=1 and err=1 in the cycle after the request.
REQ-048 Word read at addr=8 with ram_mfc tied 0: ram_enable high exactly TIMEOUT (16) cycles, then done=1 and err=1, state IDLE.
REQ-049 Drive rst_n low 2 cycles into ACCESS: ram_enable=0 and busy=0 immediately, no done pulse.
REQ-050 With req held high for back-to-back accesses: each done is followed by one IDLE cycle.
